// File: rtl/multi_trigger_pkg.sv
// Shared types and limits for the multi_trigger block (package trigger_pkg).
// Optional holdoff logic is enabled with the MULTI_TRIGGER_HOLDOFF_EN macro.
package trigger_pkg;

    localparam int unsigned MAX_CHANNELS    = 32;
    localparam int unsigned MAX_SYNC_STAGES = 4;
    localparam int unsigned MAX_PULSE_WIDTH = 255;
    localparam int unsigned MAX_HOLDOFF     = 65535;

    typedef enum logic [1:0] {
        RISE = 2'b00,
        FALL = 2'b01,
        BOTH = 2'b10
    } edge_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PULSE   = 2'b01,
        ST_HOLDOFF = 2'b10
    } trig_state_e;

    // Encoding 2'b11 is reserved and behaves as rising-edge detection.
    function automatic edge_mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'b01:   return FALL;
            2'b10:   return BOTH;
            default: return RISE;
        endcase
    endfunction

    // Smallest counter width that holds 0..max_val, at least one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 2) return 1;
        return 32'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/multi_trigger_if.sv
// Trigger bus: per-channel inputs, enables, shared mode, per-channel outputs.
interface multi_trigger_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] trigger_in;
    logic [CHANNELS-1:0] enable;
    logic [1:0]          mode;
    logic [CHANNELS-1:0] trigger_out;
    logic [CHANNELS-1:0] overrun;

    modport master (
        output trigger_in, enable, mode,
        input  trigger_out, overrun
    );

    modport slave (
        input  trigger_in, enable, mode,
        output trigger_out, overrun
    );
endinterface

// File: rtl/trigger_channel.sv
// One trigger channel: synchroniser, edge detector and pulse/holdoff FSM.
// Holdoff state and counter exist only when MULTI_TRIGGER_HOLDOFF_EN is defined.
module trigger_channel
    import trigger_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_WIDTH = 1,
    parameter int unsigned HOLDOFF     = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_trig,
    input  logic       i_en,
    input  logic [1:0] i_mode,
    output logic       o_pulse,
    output logic       o_overrun
);

    localparam int unsigned PW_LOAD = PULSE_WIDTH - 1;
    localparam int unsigned PW_W    = cnt_width(PW_LOAD);

    // Out-of-range configurations elaborate this empty marker block.
    if (SYNC_STAGES < 1 || SYNC_STAGES > MAX_SYNC_STAGES ||
        PULSE_WIDTH < 1 || PULSE_WIDTH > MAX_PULSE_WIDTH ||
        HOLDOFF > MAX_HOLDOFF) begin : g_cfg_out_of_range
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_edge;
    logic                   w_sync;
    logic                   w_edge;
    edge_mode_e             w_mode;

    trig_state_e            r_state, w_state_n;
    logic [PW_W-1:0]        r_pcnt,  w_pcnt_n;
    logic                   r_pulse, w_pulse_n;
    logic                   r_ovr,   w_ovr_n;

`ifdef MULTI_TRIGGER_HOLDOFF_EN
    localparam int unsigned HO_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam int unsigned HO_W    = cnt_width(HO_LOAD);
    logic [HO_W-1:0]        r_hcnt,  w_hcnt_n;
`endif

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_mode = decode_mode(i_mode);

    always_comb begin
        case (w_mode)
            FALL:    w_edge = ~w_sync &  r_last;
            BOTH:    w_edge =  w_sync ^  r_last;
            default: w_edge =  w_sync & ~r_last;
        endcase
    end

    // Synchroniser, history and registered edge keep tracking regardless of enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_edge <= 1'b0;
        end else begin
            r_sync[0] <= i_trig;
            for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
            r_last <= w_sync;
            r_edge <= w_edge;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
            r_pulse <= 1'b0;
            r_ovr   <= 1'b0;
`ifdef MULTI_TRIGGER_HOLDOFF_EN
            r_hcnt  <= '0;
`endif
        end else begin
            r_state <= w_state_n;
            r_pcnt  <= w_pcnt_n;
            r_pulse <= w_pulse_n;
            r_ovr   <= w_ovr_n;
`ifdef MULTI_TRIGGER_HOLDOFF_EN
            r_hcnt  <= w_hcnt_n;
`endif
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_pcnt_n  = r_pcnt;
        w_pulse_n = 1'b0;
        w_ovr_n   = 1'b0;
`ifdef MULTI_TRIGGER_HOLDOFF_EN
        w_hcnt_n  = r_hcnt;
`endif
        if (!i_en) begin
            w_state_n = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_edge) begin
                        w_state_n = ST_PULSE;
                        w_pcnt_n  = PW_W'(PW_LOAD);
                        w_pulse_n = 1'b1;
                    end
                end
                ST_PULSE: begin
                    w_ovr_n = r_edge;
                    if (r_pcnt == '0) begin
`ifdef MULTI_TRIGGER_HOLDOFF_EN
                        if (HOLDOFF > 0) begin
                            w_state_n = ST_HOLDOFF;
                            w_hcnt_n  = HO_W'(HO_LOAD);
                        end else begin
                            w_state_n = ST_IDLE;
                        end
`else
                        w_state_n = ST_IDLE;
`endif
                    end else begin
                        w_pcnt_n  = r_pcnt - PW_W'(1);
                        w_pulse_n = 1'b1;
                    end
                end
`ifdef MULTI_TRIGGER_HOLDOFF_EN
                ST_HOLDOFF: begin
                    w_ovr_n = r_edge;
                    if (r_hcnt == '0) w_state_n = ST_IDLE;
                    else              w_hcnt_n  = r_hcnt - HO_W'(1);
                end
`endif
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    assign o_pulse   = r_pulse;
    assign o_overrun = r_ovr;

endmodule

// File: rtl/multi_trigger.sv
// Multi-channel edge-triggered pulse generator; one trigger_channel per input bit.
// Define MULTI_TRIGGER_HOLDOFF_EN to build the post-pulse holdoff window.
module multi_trigger
    import trigger_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PULSE_WIDTH = 1,
    parameter int unsigned HOLDOFF     = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    multi_trigger_if.slave bus
);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_channels_out_of_range
    end

    logic [CHANNELS-1:0] w_trig_out;
    logic [CHANNELS-1:0] w_overrun;

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        trigger_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .PULSE_WIDTH (PULSE_WIDTH),
            .HOLDOFF     (HOLDOFF)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_trig    (bus.trigger_in[g]),
            .i_en      (bus.enable[g]),
            .i_mode    (bus.mode),
            .o_pulse   (w_trig_out[g]),
            .o_overrun (w_overrun[g])
        );
    end

    assign bus.trigger_out = w_trig_out;
    assign bus.overrun     = w_overrun;

endmodule

// File: doc/multi_trigger.md
MULTI_TRIGGER -- requirements
Module: multi_trigger

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of independent trigger channels, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per input, 1..4.
REQ-003 SHALL have parameter PULSE_WIDTH, default 1: output pulse length in cycles, 1..255.
REQ-004 SHALL have parameter HOLDOFF, default 0: dead cycles after each pulse, 0..65535.
REQ-005 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port trigger_in  input  CHANNELS  asynchronous variable-duration levels, one bit per channel.
REQ-008 SHALL have port enable  input  CHANNELS  per-channel enable, synchronous to clk.
REQ-009 SHALL have port mode  input  2  edge select: 00 rising, 01 falling, 10 both, 11 treated as rising.
REQ-010 SHALL have port trigger_out  output  CHANNELS  registered pulse, PULSE_WIDTH cycles per accepted edge.
REQ-011 SHALL have port overrun  output  CHANNELS  registered one-cycle flag per dropped edge.

Function
REQ-012 Each channel SHALL pass trigger_in through SYNC_STAGES flops, then a "last" flop holding the previous synchronised value.
REQ-013 Edge detect SHALL compare synchronised vs last per mode; rising = sync & !last, falling = !sync & last.
REQ-014 Latency SHALL be exactly SYNC_STAGES+1 posedges from first posedge sampling the new level to trigger_out high.
REQ-015 Per-channel FSM SHALL have states IDLE, PULSE, HOLDOFF.
REQ-016 IDLE: edge with enable=1 -> PULSE, trigger_out=1, width counter loaded PULSE_WIDTH-1.
REQ-017 PULSE: trigger_out=1; counter decrements; at 0 -> HOLDOFF if HOLDOFF>0, else IDLE.
REQ-018 HOLDOFF: trigger_out=0; counter loaded HOLDOFF-1 on entry, decrements; at 0 -> IDLE.
REQ-019 Edges detected in PULSE or HOLDOFF SHALL NOT be queued; overrun SHALL pulse 1 cycle for each, concurrent with the detect cycle.
REQ-020 Edge detected on the first IDLE cycle after PULSE/HOLDOFF SHALL be accepted.
REQ-021 enable=0 SHALL force state IDLE and trigger_out=0 next cycle, abort any pulse, suppress overrun; sync and last flops keep tracking so re-enable on a static level produces no pulse.
REQ-022 mode change SHALL take effect on the next detect cycle; an in-flight pulse completes unaltered.
REQ-023 Channels SHALL be fully independent; simultaneous edges on all channels SHALL each be accepted.
REQ-024 Counters SHALL be sized $clog2 of their maximum+1, never wrap; no arithmetic beyond decrement-to-zero.

Reset
REQ-025 rst_n low SHALL asynchronously clear sync flops, last, counters, state to IDLE, trigger_out=0, overrun=0.
REQ-026 Reset mid-pulse SHALL drop trigger_out within the same asynchronous assertion; no pulse resumes after release.
REQ-027 Input held high across reset release SHALL, with mode rising and enable=1, produce exactly one pulse (last resets to 0).

Configuration
REQ-028 Macro MULTI_TRIGGER_HOLDOFF_EN defined: HOLDOFF state and counter SHALL be built per REQ-018.
REQ-029 Macro undefined: HOLDOFF parameter SHALL be ignored, no holdoff counter built, PULSE at 0 -> IDLE directly.

Structure
REQ-030 Package trigger_pkg SHALL hold the edge-mode enum (RISE, FALL, BOTH), FSM state enum, and parameter limit constants.
REQ-031 Per-channel logic SHALL be sub-module trigger_channel, instantiated CHANNELS times by generate.

Verification
REQ-032 SYNC_STAGES=2, mode=00, ch0 0->1 before posedge 0 -> trigger_out[0] high after posedge 3, exactly PULSE_WIDTH=1 cycle.
REQ-033 PULSE_WIDTH=4, HOLDOFF=3, holdoff enabled, second rising edge detected 2 cycles into pulse -> overrun[0] one cycle, no second pulse; edge detected 8 cycles after first pulse start -> accepted.
REQ-034 mode=10, ch1 toggled high 10 cycles then low -> two pulses on trigger_out[1], 10 cycles apart.
REQ-035 rst_n asserted during cycle 2 of a 4-cycle pulse -> trigger_out immediately 0; held-high input after release -> one pulse.
REQ-036 enable[2]=0 while input rises, enable 5 cycles later with input still high -> no pulse, no overrun.
REQ-037 Build without MULTI_TRIGGER_HOLDOFF_EN, HOLDOFF=100 -> edge detected on first cycle after pulse end accepted.
